// File: rtl/hh_neuron_array_pkg.sv
// Shared types, default parameters and helpers for the time-multiplexed HH neuron array.
package hh_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } hh_state_t;

  localparam int DEF_W         = 8;
  localparam int DEF_N         = 4;
  localparam int DEF_THRESH    = 50;
  localparam int DEF_V_RESET   = 0;
  localparam int DEF_REFRAC    = 2;
  localparam int DEF_DT_SHIFT  = 1;
  localparam int DEF_GL_SHIFT  = 2;
  localparam int DEF_GK_SHIFT  = 1;
  localparam int DEF_TAU_SHIFT = 2;

  function automatic int clamp(input int x, input int lo, input int hi);
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_bits(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/hh_neuron_array_if.sv
// Request/response bundle between the stimulus source, the neuron array and the spike consumer.
interface hh_neuron_array_if #(
  parameter int W = hh_pkg::DEF_W,
  parameter int N = hh_pkg::DEF_N
);
  import hh_pkg::*;

  // Handshake: tick is a request taken only in a cycle where busy is low; each
  // accepted tick yields exactly one done pulse, after which busy drops again.
  logic           tick;
  logic [N*W-1:0] stim;
  logic           busy;
  logic           done;
  logic [N-1:0]   spike;
  logic [N*W-1:0] v_out;
  hh_state_t      state;

  modport master (output tick, stim, input busy, done, spike, v_out, state);
  modport slave  (input tick, stim, output busy, done, spike, v_out, state);

endinterface

// File: rtl/hh_neuron_array_channel_update.sv
// Combinational single-channel update: leak, potassium current, integration, gating and refractory.
module hh_channel_update
  import hh_pkg::*;
#(
  parameter int W         = DEF_W,
  parameter int THRESH    = DEF_THRESH,
  parameter int V_RESET   = DEF_V_RESET,
  parameter int REFRAC    = DEF_REFRAC,
  parameter int DT_SHIFT  = DEF_DT_SHIFT,
  parameter int GL_SHIFT  = DEF_GL_SHIFT,
  parameter int GK_SHIFT  = DEF_GK_SHIFT,
  parameter int TAU_SHIFT = DEF_TAU_SHIFT,
  parameter int RW        = cnt_bits(REFRAC)
) (
  input  logic [W-1:0]  i_v,
  input  logic [W-1:0]  i_n,
  input  logic [RW-1:0] i_r,
  input  logic [W-1:0]  i_stim,
  output logic [W-1:0]  o_v_new,
  output logic [W-1:0]  o_n_new,
  output logic [RW-1:0] o_r_new,
  output logic          o_spk
);
  // Three guard bits keep stim - i_l - i_k and v + dv exact before clamping.
  localparam int SW = W + 3;

  logic [2*W-1:0]       w_prod;
  logic [W-1:0]         w_il;
  logic [W-1:0]         w_ik;
  logic signed [SW-1:0] w_net;
  logic signed [SW-1:0] w_dv;
  logic signed [SW-1:0] w_vsum;
  logic signed [SW-1:0] w_dn;
  logic signed [SW-1:0] w_nsum;
  logic [W-1:0]         w_v_next;

  assign w_prod   = {{W{1'b0}}, i_v} * {{W{1'b0}}, i_n};
  assign w_il     = i_v >> GL_SHIFT;
  assign w_ik     = W'(w_prod >> (W + GK_SHIFT));
  assign w_net    = $signed({3'b000, i_stim}) - $signed({3'b000, w_il}) - $signed({3'b000, w_ik});
  assign w_dv     = w_net >>> DT_SHIFT;
  assign w_vsum   = $signed({3'b000, i_v}) + w_dv;
  assign w_v_next = W'(clamp(int'(w_vsum), 0, (1 << W) - 1));

  // Gating relaxes toward v; the step never overshoots, so n stays within W bits.
  assign w_dn     = ($signed({3'b000, i_v}) - $signed({3'b000, i_n})) >>> TAU_SHIFT;
  assign w_nsum   = $signed({3'b000, i_n}) + w_dn;
  assign o_n_new  = W'(w_nsum);

  always_comb begin
    o_v_new = w_v_next;
    o_r_new = i_r;
    o_spk   = 1'b0;
    if (i_r != '0) begin
      o_v_new = W'(V_RESET);
      o_r_new = i_r - RW'(1);
    end else if (int'(w_v_next) >= THRESH) begin
      o_v_new = W'(V_RESET);
      o_r_new = RW'(REFRAC);
      o_spk   = 1'b1;
    end
  end

endmodule

// File: rtl/hh_neuron_array.sv
// N-channel HH neuron array; one shared update datapath walks the channels once per accepted tick.
module hh_neuron_array
  import hh_pkg::*;
#(
  parameter int W         = DEF_W,
  parameter int N         = DEF_N,
  parameter int THRESH    = DEF_THRESH,
  parameter int V_RESET   = DEF_V_RESET,
  parameter int REFRAC    = DEF_REFRAC,
  parameter int DT_SHIFT  = DEF_DT_SHIFT,
  parameter int GL_SHIFT  = DEF_GL_SHIFT,
  parameter int GK_SHIFT  = DEF_GK_SHIFT,
  parameter int TAU_SHIFT = DEF_TAU_SHIFT
) (
  input logic              clk,
  input logic              rst_n,
  hh_neuron_array_if.slave io_bus
);
  localparam int RW = cnt_bits(REFRAC);
  localparam int IW = cnt_bits(N - 1);

  hh_state_t      r_state;
  logic [IW-1:0]  r_idx;
  logic [N*W-1:0] r_stim;
  logic [W-1:0]   r_v [N];
  logic [W-1:0]   r_n [N];
  logic [RW-1:0]  r_r [N];
  logic [N-1:0]   r_spike;
  logic           r_done;

  logic [W-1:0]   w_v_new;
  logic [W-1:0]   w_n_new;
  logic [RW-1:0]  w_r_new;
  logic           w_spk;
  logic [N*W-1:0] w_v_out;

  hh_channel_update #(
    .W(W), .THRESH(THRESH), .V_RESET(V_RESET), .REFRAC(REFRAC),
    .DT_SHIFT(DT_SHIFT), .GL_SHIFT(GL_SHIFT), .GK_SHIFT(GK_SHIFT),
    .TAU_SHIFT(TAU_SHIFT), .RW(RW)
  ) u_update (
    .i_v     (r_v[r_idx]),
    .i_n     (r_n[r_idx]),
    .i_r     (r_r[r_idx]),
    .i_stim  (r_stim[r_idx*W +: W]),
    .o_v_new (w_v_new),
    .o_n_new (w_n_new),
    .o_r_new (w_r_new),
    .o_spk   (w_spk)
  );

  // Stimulus is taken from the snapshot only, so stim may change freely mid-sweep.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_stim  <= '0;
      r_spike <= '0;
      r_done  <= 1'b0;
      for (int k = 0; k < N; k++) begin
        r_v[k] <= '0;
        r_n[k] <= '0;
        r_r[k] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (io_bus.tick) begin
            r_stim  <= io_bus.stim;
            r_idx   <= '0;
            r_state <= UPDATE;
          end
        end
        UPDATE: begin
          r_v[r_idx]     <= w_v_new;
          r_n[r_idx]     <= w_n_new;
          r_r[r_idx]     <= w_r_new;
          r_spike[r_idx] <= w_spk;
          if (r_idx == IW'(N - 1)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_v_out = '0;
    for (int k = 0; k < N; k++) w_v_out[k*W +: W] = r_v[k];
  end

  assign io_bus.busy  = (r_state != IDLE);
  assign io_bus.done  = r_done;
  assign io_bus.spike = r_spike;
  assign io_bus.v_out = w_v_out;
  assign io_bus.state = r_state;

endmodule
